// File: rtl/cr_rst_seq.sv
// Staged reset sequencer: asserts every domain's reset together, then releases
// domains one at a time in index order, each step gated by its ack or a timeout.
module cr_rst_seq #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int TMO_CYCLES  = 255,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] dom_rst_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               busy,
  output logic               done,
  output logic [NUM_DOM-1:0] tmo_err
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  // state is kept as a named internal signal so checkers can bind to it.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  logic             tmo_hit;
  logic             ack_cur;
  logic [IDX_W-1:0] idx_nxt;

  assign tmo_hit = (cnt == TMO_LAST);
  assign ack_cur = dom_rst_ack[idx];
  assign idx_nxt = idx + IDX_W'(1);

  // Request handshake: sw_rst_req is a one-cycle pulse taken only while busy
  // is low; pulses seen while busy (including the done cycle) are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      dom_rst_n <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      tmo_err   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          dom_rst_n <= '1;
          if (sw_rst_req) begin
            dom_rst_n <= '0;
            tmo_err   <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (&dom_rst_ack) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (tmo_hit) begin
            // Flag every domain that never confirmed it entered reset.
            tmo_err <= tmo_err | ~dom_rst_ack;
            cnt     <= '0;
            state   <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt          <= '0;
            idx          <= '0;
            dom_rst_n[0] <= 1'b1;
            state        <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (!ack_cur || tmo_hit) begin
            if (ack_cur) begin
              tmo_err[idx] <= 1'b1;
            end
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Release the next domain on the same edge the index advances.
              idx       <= idx_nxt;
              cnt       <= '0;
              dom_rst_n <= dom_rst_n | (NUM_DOM'(1) << idx_nxt);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_rst_seq.sv
// Bench for cr_rst_seq: a procedural sequence model predicts the outputs of every
// clock edge into a queue; a monitor pops one entry per cycle and compares.
module tb_cr_rst_seq;

  localparam int NUM_DOM     = 3;
  localparam int HOLD_CYCLES = 4;
  localparam int TMO_CYCLES  = 8;
  localparam int CNT_W       = 4;
  localparam int W           = 2 * NUM_DOM + 2;

  logic               clk;
  logic               rst;
  logic               sw_rst_req;
  logic [NUM_DOM-1:0] dom_rst_ack;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               busy;
  logic               done;
  logic [NUM_DOM-1:0] tmo_err;

  cr_rst_seq #(
    .NUM_DOM    (NUM_DOM),
    .HOLD_CYCLES(HOLD_CYCLES),
    .TMO_CYCLES (TMO_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .dom_rst_ack(dom_rst_ack),
    .dom_rst_n  (dom_rst_n),
    .busy       (busy),
    .done       (done),
    .tmo_err    (tmo_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- ack environment ----------------
  // Each domain reports "in reset" after a per-domain lag; faults force it.
  logic [NUM_DOM-1:0] hist [0:2];
  int                 lag [NUM_DOM];
  logic [NUM_DOM-1:0] stuck1;
  logic [NUM_DOM-1:0] stuck0;

  always @(negedge clk) begin
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = $isunknown(dom_rst_n) ? '0 : dom_rst_n;
    for (int d = 0; d < NUM_DOM; d++) begin
      dom_rst_ack[d] = (~hist[lag[d]][d] | stuck1[d]) & ~stuck0[d];
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           checks;
  int           passes;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dom_rst_n", 16'(dom_rst_n), 16'(mon_e[W-1 -: NUM_DOM]));
      chk("busy",      16'(busy),      16'(mon_e[NUM_DOM+1]));
      chk("done",      16'(done),      16'(mon_e[NUM_DOM]));
      chk("tmo_err",   16'(tmo_err),   16'(mon_e[NUM_DOM-1:0]));
    end
  end

  // ---------------- reference model ----------------
  // Written as the sequence a person would describe: hold, release each domain
  // in turn, done, idle until asked, wait for every domain to enter reset.
  logic [NUM_DOM-1:0] m_rst_n;
  logic [NUM_DOM-1:0] m_tmo;
  logic               m_busy;
  logic               m_done;
  logic               s_rst;
  logic               s_req;
  logic [NUM_DOM-1:0] s_ack;

  task automatic push();
    exp_q.push_back({m_rst_n, m_busy, m_done, m_tmo});
    m_done = 1'b0;
  endtask

  // Take one clock edge; a reset edge is fully handled here and reported as abort.
  task automatic edge_in(output bit ab);
    @(posedge clk);
    s_rst = rst;
    s_req = sw_rst_req;
    s_ack = dom_rst_ack;
    ab    = (s_rst === 1'b1);
    if (ab) begin
      m_rst_n = '0;
      m_busy  = 1'b1;
      m_done  = 1'b0;
      m_tmo   = '0;
      push();
    end
  endtask

  task automatic run_seq(output bit ab);
    forever begin
      for (int k = 1; k <= HOLD_CYCLES; k++) begin
        edge_in(ab);
        if (ab) return;
        if (k == HOLD_CYCLES) m_rst_n[0] = 1'b1;
        push();
      end
      for (int d = 0; d < NUM_DOM; d++) begin
        for (int w = 1; w <= TMO_CYCLES; w++) begin
          edge_in(ab);
          if (ab) return;
          if (!s_ack[d]) break;
          if (w == TMO_CYCLES) begin
            m_tmo[d] = 1'b1;
            break;
          end
          push();
        end
        if (d == NUM_DOM - 1) m_done = 1'b1;
        else m_rst_n[d+1] = 1'b1;
        push();
      end
      edge_in(ab);
      if (ab) return;
      m_busy = 1'b0;
      push();
      forever begin
        edge_in(ab);
        if (ab) return;
        if (s_req) begin
          m_rst_n = '0;
          m_tmo   = '0;
          m_busy  = 1'b1;
          push();
          break;
        end
        push();
      end
      for (int w = 1; w <= TMO_CYCLES; w++) begin
        edge_in(ab);
        if (ab) return;
        if (&s_ack) break;
        if (w == TMO_CYCLES) begin
          m_tmo = m_tmo | ~s_ack;
          break;
        end
        push();
      end
      push();
    end
  endtask

  initial begin : ref_model
    bit ab;
    m_done = 1'b0;
    ab = 1'b0;
    while (!ab) edge_in(ab);
    forever run_seq(ab);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 16'(busy), 16'(0));
  endtask

  task automatic set_lag(input int l);
    for (int d = 0; d < NUM_DOM; d++) lag[d] = l;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int n;
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    stuck1     = '0;
    stuck0     = '0;
    set_lag(1);

    // power-on: rst across three edges
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle(100);
    repeat (4) @(negedge clk);

    // healthy software sequence
    pulse_req();
    wait_idle(100);
    repeat (3) @(negedge clk);

    // domain 1 never leaves reset
    stuck1 = 3'b010;
    pulse_req();
    wait_idle(100);
    repeat (5) @(negedge clk);
    stuck1 = '0;
    repeat (3) @(negedge clk);

    // domain 2 never enters reset, then a healthy run clears the flags
    stuck0 = 3'b100;
    pulse_req();
    wait_idle(100);
    stuck0 = '0;
    repeat (3) @(negedge clk);
    pulse_req();
    wait_idle(100);
    repeat (3) @(negedge clk);

    // requests during the whole busy window, including the done cycle
    pulse_req();
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      sw_rst_req = 1'b1;
      @(negedge clk);
      n++;
    end
    sw_rst_req = 1'b0;
    chk("busy_window_end", 16'(busy), 16'(0));
    repeat (10) @(negedge clk);

    // reset while domain 1 is the one being released
    pulse_req();
    n = 0;
    while (dom_rst_n !== 3'b011 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_idx1", 16'(dom_rst_n), 16'(3'b011));
    pulse_rst();
    wait_idle(100);
    repeat (3) @(negedge clk);

    // randomized sequences: lags, faults, stray requests, stray resets
    for (int it = 0; it < 40; it++) begin
      for (int d = 0; d < NUM_DOM; d++) lag[d] = $urandom_range(0, 2);
      stuck1 = ($urandom_range(0, 3) == 0) ? NUM_DOM'($urandom_range(0, 7)) : '0;
      stuck0 = ($urandom_range(0, 3) == 0) ? NUM_DOM'($urandom_range(0, 7)) : '0;
      pulse_req();
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
        if ($urandom_range(0, 39) == 0) pulse_rst();
        else if ($urandom_range(0, 5) == 0) pulse_req();
        else @(negedge clk);
        n++;
      end
      wait_idle(100);
      stuck1 = '0;
      stuck0 = '0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
